bcd_to_bin_seq: RTL
===================

// Module: bcd_to_bin_seq
// PURPOSE
//  Iterative BCD-to-binary converter (reverse double dabble). Inverse of the add-3
//  binary-to-BCD path in wb_control. Turns packed BCD (e.g. keypad/display value)
//  back into a binary count for the Wishbone control registers.
//  Method: shift right one bit per clock, then subtract 3 from each BCD digit >= 8.
// PARAMETERS
//  DIGITS  4   number of packed BCD digits in bcd_in
//  BIN_W   14  binary result width; must be >= ceil(log2(10^DIGITS))
// PORTS
//  clk      in   1           system clock, rising edge
//  reset    in   1           asynchronous, active-high; clears all state/outputs
//  start    in   1           request conversion; sampled only in IDLE
//  bcd_in   in   4*DIGITS    packed BCD, digit 0 = bits[3:0]; sampled with start
//  bin_out  out  BIN_W       binary result, registered, held until next done
//  busy     out  1           high from accepted start until done cycle inclusive
//  done     out  1           one-cycle pulse: bin_out/err valid
//  err      out  1           last request had a digit > 9; held until next done
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, bin_out=0, busy=0, done=0, err=0,
//   shift register and counter = 0.
//  Datapath: shift reg sr = {bcd[4*DIGITS-1:0], bin[BIN_W-1:0]};
//   counter cnt, width $clog2(BIN_W+1).
//  States:
//   IDLE:  busy=0. start=1 and all digits <= 9: sr <= {bcd_in, 0}, cnt <= 0,
//          -> SHIFT. start=1 with any digit >= 10: -> DONE with err_next=1,
//          no shift. start=0: stay.
//   SHIFT: busy=1. Each clock: t = sr >> 1; then every 4-bit digit of t's BCD
//          field >= 8 gets -3; sr <= result; cnt <= cnt+1.
//          After the BIN_W-th shift (cnt == BIN_W-1 at the edge) -> DONE.
//   DONE:  busy=1, done=1 for exactly one cycle.
//          Entering DONE: bin_out <= sr[BIN_W-1:0], err <= 0 (valid path);
//          or bin_out <= 0, err <= 1 (invalid path). Next clock -> IDLE.
//  Latency, valid input: start sampled at edge E; done high in the cycle after
//   edge E+BIN_W (15 clocks from start for defaults).
//  Latency, invalid input: done high in the cycle after edge E+1.
//  Corrections after the final shift act on a zero BCD field and are harmless.
//   No overflow is possible when BIN_W meets the parameter rule.
//  start while busy (SHIFT or DONE) is ignored, never queued.
//   bcd_in changes during SHIFT have no effect.
//  Earliest next accept: start high in the IDLE cycle right after done.
//  Reset mid-conversion: partial result is discarded, no done pulse.
//   bin_out returns to 0.
//  bin_out/err change only on entry to DONE or on reset; stable otherwise.
// TESTING
//  1 reset, bcd_in=16'h0000, start 1 clk -> done after 15 clks, bin_out=0, err=0
//  2 bcd_in=16'h9999 -> bin_out=14'd9999 (0x270F); busy high 15 cycles;
//    done exactly 1 cycle
//  3 bcd_in=16'h1234 -> 0x04D2; then 16'h0507 -> 0x01FB;
//    start in IDLE cycle right after the first done is accepted
//  4 bcd_in=16'h12A4 -> done 2 clks after start, err=1, bin_out=0;
//    next valid 16'h0042 -> err=0, bin_out=42
//  5 start 16'h0100; pulse start with 16'h9999 at shift 5 -> ignored, result 100
//  6 start 16'h8765; assert reset at shift 7 -> all outputs 0 immediately,
//    no done; after release, 16'h0001 -> 1

Source files
------------

// File: rtl/bcd_to_bin_seq_if.sv
// Handshake and data bundle for the iterative BCD-to-binary converter.
interface bcd_to_bin_seq_if #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [BIN_W-1:0]      bin_out;
    logic                  busy;
    logic                  done;
    logic                  err;

    // Requester side: issues conversions and observes results.
    modport master (
        output start, bcd_in,
        input  bin_out, busy, done, err
    );

    // Converter side.
    modport slave (
        input  start, bcd_in,
        output bin_out, busy, done, err
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter (reverse double dabble).
// Each clock, the {bcd, bin} register shifts right by one bit. Every BCD digit
// that is then >= 8 is reduced by 3. After BIN_W shifts the binary field holds
// the result. A request that contains a non-decimal digit is rejected with err.
module bcd_to_bin_seq #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic               clk,
    input  logic               reset,
    bcd_to_bin_seq_if.slave    bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

    // REJECT holds a bad request for one cycle, so its done pulse arrives two
    // clocks after start.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REJECT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    logic [SR_W-1:0]    sr;
    logic [CNT_W-1:0]   cnt;
    logic [SR_W-1:0]    shifted_c;
    logic [SR_W-1:0]    sr_step_c;
    logic               bad_digit_c;

    // Flag any incoming digit outside 0..9.
    always_comb begin
        bad_digit_c = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit_c = 1'b1;
            end
        end
    end

    // One conversion step: shift right, then subtract 3 from each BCD digit >= 8.
    always_comb begin
        shifted_c = sr >> 1;
        sr_step_c = shifted_c;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (shifted_c[BIN_W + 4*i +: 4] >= 4'd8) begin
                sr_step_c[BIN_W + 4*i +: 4] = shifted_c[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    // Control FSM, datapath, and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            bus.bin_out <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        if (bad_digit_c) begin
                            state <= REJECT;
                        end else begin
                            sr    <= {bus.bcd_in, BIN_W'(0)};
                            cnt   <= '0;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    sr  <= sr_step_c;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_SHIFT) begin
                        state       <= DONE;
                        bus.bin_out <= sr_step_c[BIN_W-1:0];
                        bus.err     <= 1'b0;
                        bus.done    <= 1'b1;
                    end
                end
                REJECT: begin
                    state       <= DONE;
                    bus.bin_out <= '0;
                    bus.err     <= 1'b1;
                    bus.done    <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
